conv_tile_sched: RTL and testbench

- Layer-level tile scheduler for the convolution accelerator.
- Walks the output and input tile loops of one layer and, per tile, sequences the in_fm/weight load engines, the out_fm clear engine, the conv computing control path (conv_computing_start / conv_computing_done / conv_tile_reset) and the out_fm store engine.
- Sits between the host start/done interface and the conv tile datapath. It exports the current tile indices to the address generators of the load/store engines.

---
 rtl/conv_tile_sched.sv | 165 ++++++++++++++++
 tb/tb_conv_tile_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_sched.sv
// Layer-level tile scheduler: walks n/r/c/m tile loops and sequences the load,
// clear, compute, tile-reset and store phases of every tile.
module conv_tile_sched #(
  parameter int unsigned R_TILES = 4,
  parameter int unsigned C_TILES = 4,
  parameter int unsigned M_TILES = 2,
  parameter int unsigned N_TILES = 2,
  parameter int unsigned IW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          layer_start,
  output logic          layer_done,
  output logic          busy,
  output logic          in_fm_ld_start,
  input  logic          in_fm_ld_done,
  output logic          weight_ld_start,
  input  logic          weight_ld_done,
  output logic          out_fm_clr_start,
  input  logic          out_fm_clr_done,
  output logic          conv_computing_start,
  input  logic          conv_computing_done,
  output logic          conv_tile_reset,
  output logic          out_fm_st_start,
  input  logic          out_fm_st_done,
  output logic [IW-1:0] row_tile_idx,
  output logic [IW-1:0] col_tile_idx,
  output logic [IW-1:0] in_ch_tile_idx,
  output logic [IW-1:0] out_ch_tile_idx
);

  localparam logic [IW-1:0] R_LAST = IW'(R_TILES - 1);
  localparam logic [IW-1:0] C_LAST = IW'(C_TILES - 1);
  localparam logic [IW-1:0] M_LAST = IW'(M_TILES - 1);
  localparam logic [IW-1:0] N_LAST = IW'(N_TILES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_TILE_RST,
    S_STORE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          first_q;
  logic          in_ok_q, in_ok_d;
  logic          w_ok_q, w_ok_d;
  logic          clr_ok_q, clr_ok_d;
  logic [IW-1:0] r_q, r_d;
  logic [IW-1:0] c_q, c_d;
  logic [IW-1:0] m_q, m_d;
  logic [IW-1:0] n_q, n_d;

  // first_q marks the first cycle after any state change; it qualifies the start pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      first_q  <= 1'b0;
      in_ok_q  <= 1'b0;
      w_ok_q   <= 1'b0;
      clr_ok_q <= 1'b0;
      r_q      <= '0;
      c_q      <= '0;
      m_q      <= '0;
      n_q      <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= (state_d != state_q);
      in_ok_q  <= in_ok_d;
      w_ok_q   <= w_ok_d;
      clr_ok_q <= clr_ok_d;
      r_q      <= r_d;
      c_q      <= c_d;
      m_q      <= m_d;
      n_q      <= n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ok_d  = in_ok_q;
    w_ok_d   = w_ok_q;
    clr_ok_d = clr_ok_q;
    r_d      = r_q;
    c_d      = c_q;
    m_d      = m_q;
    n_d      = n_q;
    case (state_q)
      S_IDLE: begin
        if (layer_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        // A clear is only needed for the first input-channel tile.
        in_ok_d  = in_ok_q | in_fm_ld_done;
        w_ok_d   = w_ok_q | weight_ld_done;
        clr_ok_d = clr_ok_q | out_fm_clr_done | (m_q != '0);
        if (in_ok_d && w_ok_d && clr_ok_d) begin
          state_d  = S_COMPUTE;
          in_ok_d  = 1'b0;
          w_ok_d   = 1'b0;
          clr_ok_d = 1'b0;
        end
      end
      S_COMPUTE: begin
        if (conv_computing_done) state_d = S_TILE_RST;
      end
      S_TILE_RST: begin
        if (m_q != M_LAST) begin
          m_d     = m_q + IW'(1);
          state_d = S_LOAD;
        end else begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        if (out_fm_st_done) begin
          if (n_q == N_LAST && r_q == R_LAST && c_q == C_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            m_d     = '0;
            if (c_q == C_LAST) begin
              c_d = '0;
              if (r_q == R_LAST) begin
                r_d = '0;
                n_d = n_q + IW'(1);
              end else begin
                r_d = r_q + IW'(1);
              end
            end else begin
              c_d = c_q + IW'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        r_d     = '0;
        c_d     = '0;
        m_d     = '0;
        n_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy                 = (state_q != S_IDLE);
    in_fm_ld_start       = (state_q == S_LOAD) && first_q;
    weight_ld_start      = (state_q == S_LOAD) && first_q;
    out_fm_clr_start     = (state_q == S_LOAD) && first_q && (m_q == '0);
    conv_computing_start = (state_q == S_COMPUTE);
    conv_tile_reset      = (state_q == S_TILE_RST);
    out_fm_st_start      = (state_q == S_STORE) && first_q;
    layer_done           = (state_q == S_DONE);
  end

  assign row_tile_idx    = r_q;
  assign col_tile_idx    = c_q;
  assign in_ch_tile_idx  = m_q;
  assign out_ch_tile_idx = n_q;

endmodule

// File: tb/tb_conv_tile_sched.sv
// Bench for conv_tile_sched: the bench plays every engine with random latencies
// and checks each cycle against the expected tile walk and phase timing.
module tb_conv_tile_sched;

  localparam int unsigned RT = 2;
  localparam int unsigned CT = 2;
  localparam int unsigned MT = 2;
  localparam int unsigned NT = 2;
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          layer_start = 1'b0;
  logic          in_fm_ld_done = 1'b0;
  logic          weight_ld_done = 1'b0;
  logic          out_fm_clr_done = 1'b0;
  logic          conv_computing_done = 1'b0;
  logic          out_fm_st_done = 1'b0;
  logic          layer_done, busy, in_fm_ld_start, weight_ld_start, out_fm_clr_start;
  logic          conv_computing_start, conv_tile_reset, out_fm_st_start;
  logic [IW-1:0] row_tile_idx, col_tile_idx, in_ch_tile_idx, out_ch_tile_idx;

  int checks = 0;
  int errors = 0;
  int tr_cnt = 0;
  int st_cnt = 0;
  int done_cnt = 0;

  conv_tile_sched #(
    .R_TILES(RT), .C_TILES(CT), .M_TILES(MT), .N_TILES(NT), .IW(IW)
  ) dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .layer_done(layer_done), .busy(busy),
    .in_fm_ld_start(in_fm_ld_start), .in_fm_ld_done(in_fm_ld_done),
    .weight_ld_start(weight_ld_start), .weight_ld_done(weight_ld_done),
    .out_fm_clr_start(out_fm_clr_start), .out_fm_clr_done(out_fm_clr_done),
    .conv_computing_start(conv_computing_start), .conv_computing_done(conv_computing_done),
    .conv_tile_reset(conv_tile_reset),
    .out_fm_st_start(out_fm_st_start), .out_fm_st_done(out_fm_st_done),
    .row_tile_idx(row_tile_idx), .col_tile_idx(col_tile_idx),
    .in_ch_tile_idx(in_ch_tile_idx), .out_ch_tile_idx(out_ch_tile_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {busy, in_fm_ld_start, weight_ld_start, out_fm_clr_start,
            conv_computing_start, conv_tile_reset, out_fm_st_start, layer_done};
  endfunction

  function automatic logic [31:0] idx();
    return {out_ch_tile_idx, row_tile_idx, col_tile_idx, in_ch_tile_idx};
  endfunction

  function automatic logic [7:0] ev(bit b, bit ld, bit clr, bit comp, bit trst, bit st, bit dn);
    return {b, ld, ld, clr, comp, trst, st, dn};
  endfunction

  function automatic logic [31:0] eidx(int n, int r, int c, int m);
    return {8'(n), 8'(r), 8'(c), 8'(m)};
  endfunction

  function automatic logic rnd();
    return ($urandom_range(3) == 0);
  endfunction

  task automatic quiet();
    layer_start = 0; in_fm_ld_done = 0; weight_ld_done = 0;
    out_fm_clr_done = 0; conv_computing_done = 0; out_fm_st_done = 0;
  endtask

  // Entered at the falling edge of the first LOAD cycle of tile (n,r,c,m).
  task automatic do_tile(input int n, input int r, input int c, input int m,
                         input int mode, input bit abort, output bit aborted);
    int di, dw, dc, dmax, dcomp;
    logic [31:0] ix;
    aborted = 0;
    ix = eidx(n, r, c, m);
    di = $urandom_range(6); dw = $urandom_range(6); dc = $urandom_range(6);
    if (mode == 1) begin di = 2; dw = 5; dc = 9; end
    else if (mode == 2) begin dw = di; dc = di; end
    dmax = (di > dw) ? di : dw;
    if (m == 0 && dc > dmax) dmax = dc;
    for (int k = 0; k <= dmax; k++) begin
      chk("load_outs", outs(), ev(1, k == 0, (k == 0) && (m == 0), 0, 0, 0, 0));
      chk("load_idx", idx(), ix);
      in_fm_ld_done       = (k == di);
      weight_ld_done      = (k == dw);
      out_fm_clr_done     = (m == 0) && (k == dc);
      conv_computing_done = rnd();
      out_fm_st_done      = rnd();
      layer_start         = rnd();
      @(negedge clk);
    end
    dcomp = $urandom_range(4);
    for (int j = 0; j <= dcomp; j++) begin
      chk("comp_outs", outs(), ev(1, 0, 0, 1, 0, 0, 0));
      chk("comp_idx", idx(), ix);
      if (abort) begin
        quiet();
        rst = 1;
        #1;
        chk("midrst_outs", outs(), 8'h00);
        chk("midrst_idx", idx(), 32'h0);
        #1 rst = 0;
        aborted = 1;
        return;
      end
      conv_computing_done = (j == dcomp);
      in_fm_ld_done       = (j < dcomp) && rnd();
      weight_ld_done      = (j < dcomp) && rnd();
      out_fm_clr_done     = (j < dcomp) && rnd();
      out_fm_st_done      = rnd();
      layer_start         = rnd();
      @(negedge clk);
    end
    chk("trst_outs", outs(), ev(1, 0, 0, 0, 1, 0, 0));
    chk("trst_idx", idx(), ix);
    if (conv_tile_reset === 1'b1) tr_cnt++;
    quiet();
    in_fm_ld_done  = rnd();
    weight_ld_done = rnd();
    layer_start    = rnd();
    @(negedge clk);
  endtask

  task automatic do_store(input int n, input int r, input int c);
    int ds;
    ds = $urandom_range(4);
    for (int j = 0; j <= ds; j++) begin
      chk("store_outs", outs(), ev(1, 0, 0, 0, 0, j == 0, 0));
      chk("store_idx", idx(), eidx(n, r, c, MT - 1));
      if (j == 0 && out_fm_st_start === 1'b1) st_cnt++;
      out_fm_st_done      = (j == ds);
      conv_computing_done = rnd();
      in_fm_ld_done       = rnd();
      weight_ld_done      = rnd();
      out_fm_clr_done     = rnd();
      layer_start         = rnd();
      @(negedge clk);
    end
    quiet();
  endtask

  // Expected order is the plain n/r/c/m loop nest; abort_tile<0 runs the full layer.
  task automatic run_layer(input int abort_tile);
    int t;
    bit aborted;
    t = 0;
    chk("idle_outs", outs(), 8'h00);
    quiet();
    layer_start = 1;
    @(negedge clk);
    for (int n = 0; n < NT; n++)
      for (int r = 0; r < RT; r++)
        for (int c = 0; c < CT; c++) begin
          for (int m = 0; m < MT; m++) begin
            do_tile(n, r, c, m, (t == 0) ? 1 : ((t % 3 == 1) ? 2 : 0), t == abort_tile, aborted);
            if (aborted) return;
            t++;
          end
          do_store(n, r, c);
        end
    chk("done_outs", outs(), ev(1, 0, 0, 0, 0, 0, 1));
    chk("done_idx", idx(), eidx(NT - 1, RT - 1, CT - 1, MT - 1));
    if (layer_done === 1'b1) done_cnt++;
    layer_start = 1;
    @(negedge clk);
    chk("end_idle_outs", outs(), 8'h00);
    chk("end_idle_idx", idx(), 32'h0);
    quiet();
  endtask

  initial begin
    quiet();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 8'h00);
    chk("reset_idx", idx(), 32'h0);
    rst = 0;
    @(negedge clk);
    chk("idle_after_reset", outs(), 8'h00);

    run_layer(-1);
    chk("tile_reset_count", tr_cnt, NT * RT * CT * MT);
    chk("store_count", st_cnt, NT * RT * CT);
    chk("layer_done_count", done_cnt, 1);

    run_layer(5);
    for (int k = 0; k < 4; k++) begin
      in_fm_ld_done = 1; weight_ld_done = 1; out_fm_clr_done = 1;
      conv_computing_done = 1; out_fm_st_done = 1;
      @(negedge clk);
      chk("post_rst_idle_outs", outs(), 8'h00);
      chk("post_rst_idle_idx", idx(), 32'h0);
    end
    quiet();
    @(negedge clk);

    tr_cnt = 0; st_cnt = 0; done_cnt = 0;
    run_layer(-1);
    chk("tile_reset_count2", tr_cnt, NT * RT * CT * MT);
    chk("store_count2", st_cnt, NT * RT * CT);
    chk("layer_done_count2", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
